brick_collide: RTL

Ball-versus-brick collision engine, directly upstream of the brick grid store. It runs once per game tick on `start`. It probes up to three grid cells at the ball's leading edge through the grid's row/col read port and clears breakable bricks with the grid's CLEAR command. It then reports bounce flags and hit count to the ball-motion logic.

---
 rtl/brick_collide.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/brick_collide.sv
// rtl/brick_collide.sv - ball-versus-brick collision engine driving the brick grid store
//
// Purpose: once per game tick (start), probe up to three grid cells at the
// ball's leading edge (X, Y, then diagonal D if X and Y both missed), clear
// breakable bricks (kinds 1..6) with the grid CLEAR command, and report the
// bounce flags, the number of bricks cleared and the first kind hit.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   start                        one-cycle tick request, accepted in IDLE only
//   ball_x, ball_y, dir_x, dir_y ball centre and direction, latched on start
//   grid_row, grid_col           registered cell address to the grid
//   grid_en, grid_func, grid_in  grid command strobe, function (CLEAR), data
//   grid_out, grid_busy          combinational brick kind at address, grid stall
//   done                         one-cycle completion pulse
//   flip_x, flip_y, hits, hit_kind  tick results, held until next start

module brick_collide #(
    parameter int COLS    = 32,
    parameter int ROWS    = 24,
    parameter int CELL_W  = 10,
    parameter int CELL_H  = 20,
    parameter int FIELD_W = 320,
    parameter int FIELD_H = 480,
    parameter int BALL_R  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic       dir_x,
    input  logic       dir_y,
    output logic [6:0] grid_row,
    output logic [6:0] grid_col,
    output logic       grid_en,
    output logic [1:0] grid_func,
    output logic [2:0] grid_in,
    input  logic [2:0] grid_out,
    input  logic       grid_busy,
    output logic       done,
    output logic       flip_x,
    output logic       flip_y,
    output logic [1:0] hits,
    output logic [2:0] hit_kind
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_X,
        S_READ_X,
        S_CLR_X,
        S_ADDR_Y,
        S_READ_Y,
        S_CLR_Y,
        S_ADDR_D,
        S_READ_D,
        S_CLR_D,
        S_DONE
    } state_t;

    // Probe arithmetic is done in 10 bits so ball + radius never wraps.
    localparam logic [9:0] R_V    = 10'(BALL_R);
    localparam logic [9:0] CW_V   = 10'(CELL_W);
    localparam logic [9:0] CH_V   = 10'(CELL_H);
    localparam logic [9:0] FW_V   = 10'(FIELD_W);
    localparam logic [9:0] FH_V   = 10'(FIELD_H);
    localparam logic [9:0] ROWS_V = 10'(ROWS);
    localparam logic [9:0] COLS_V = 10'(COLS);

    state_t     state_q, state_d;
    logic [8:0] bx_q, bx_d;
    logic [8:0] by_q, by_d;
    logic       dx_q, dx_d;
    logic       dy_q, dy_d;
    logic [6:0] row_q, row_d;
    logic [6:0] col_q, col_d;
    logic       oob_q, oob_d;
    logic       flip_x_q, flip_x_d;
    logic       flip_y_q, flip_y_d;
    logic [1:0] hits_q, hits_d;
    logic [2:0] kind_q, kind_d;

    // Probe point for the current ADDR_* state.
    logic       use_dx, use_dy;
    logic       x_uf, y_uf;
    logic [9:0] px, py;
    logic [9:0] col_full, row_full;
    logic       probe_oob;
    logic [6:0] probe_row, probe_col;

    always_comb begin
        use_dx = (state_q == S_ADDR_X) || (state_q == S_ADDR_D);
        use_dy = (state_q == S_ADDR_Y) || (state_q == S_ADDR_D);
        x_uf   = 1'b0;
        y_uf   = 1'b0;
        px     = {1'b0, bx_q};
        py     = {1'b0, by_q};
        if (use_dx) begin
            if (dx_q) begin
                px = {1'b0, bx_q} + R_V;
            end else begin
                x_uf = ({1'b0, bx_q} < R_V);
                px   = {1'b0, bx_q} - R_V;
            end
        end
        if (use_dy) begin
            if (dy_q) begin
                py = {1'b0, by_q} + R_V;
            end else begin
                y_uf = ({1'b0, by_q} < R_V);
                py   = {1'b0, by_q} - R_V;
            end
        end
        col_full  = px / CW_V;
        row_full  = py / CH_V;
        probe_oob = x_uf || y_uf || (px >= FW_V) || (py >= FH_V) ||
                    (row_full >= ROWS_V) || (col_full >= COLS_V);
        // Out-of-field probes still drive an address, clamped to cell 0.
        probe_row = probe_oob ? 7'd0 : row_full[6:0];
        probe_col = probe_oob ? 7'd0 : col_full[6:0];
    end

    // An out-of-field probe reads as empty whatever the grid returns.
    logic [2:0] kind_s;
    logic       hit_s;
    logic       breakable_s;

    always_comb begin
        kind_s      = oob_q ? 3'd0 : grid_out;
        hit_s       = (kind_s != 3'd0);
        breakable_s = hit_s && (kind_s != 3'd7);
    end

    always_comb begin
        state_d  = state_q;
        bx_d     = bx_q;
        by_d     = by_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        row_d    = row_q;
        col_d    = col_q;
        oob_d    = oob_q;
        flip_x_d = flip_x_q;
        flip_y_d = flip_y_q;
        hits_d   = hits_q;
        kind_d   = kind_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bx_d     = ball_x;
                    by_d     = ball_y;
                    dx_d     = dir_x;
                    dy_d     = dir_y;
                    flip_x_d = 1'b0;
                    flip_y_d = 1'b0;
                    hits_d   = 2'd0;
                    kind_d   = 3'd0;
                    state_d  = S_ADDR_X;
                end
            end
            S_ADDR_X, S_ADDR_Y, S_ADDR_D: begin
                if (!grid_busy) begin
                    row_d = probe_row;
                    col_d = probe_col;
                    oob_d = probe_oob;
                    case (state_q)
                        S_ADDR_X: state_d = S_READ_X;
                        S_ADDR_Y: state_d = S_READ_Y;
                        default:  state_d = S_READ_D;
                    endcase
                end
            end
            S_READ_X: begin
                if (!grid_busy) begin
                    if (hit_s) begin
                        flip_x_d = 1'b1;
                        if (kind_q == 3'd0) kind_d = kind_s;
                    end
                    if (breakable_s) begin
                        hits_d  = hits_q + 2'd1;
                        state_d = S_CLR_X;
                    end else begin
                        state_d = S_ADDR_Y;
                    end
                end
            end
            S_READ_Y: begin
                if (!grid_busy) begin
                    if (hit_s) begin
                        flip_y_d = 1'b1;
                        if (kind_q == 3'd0) kind_d = kind_s;
                    end
                    if (breakable_s) begin
                        hits_d  = hits_q + 2'd1;
                        state_d = S_CLR_Y;
                    end else if (flip_x_q || hit_s) begin
                        state_d = S_DONE;
                    end else begin
                        // Diagonal only when both edge probes were clear.
                        state_d = S_ADDR_D;
                    end
                end
            end
            S_READ_D: begin
                if (!grid_busy) begin
                    if (hit_s) begin
                        flip_x_d = 1'b1;
                        flip_y_d = 1'b1;
                        if (kind_q == 3'd0) kind_d = kind_s;
                    end
                    if (breakable_s) begin
                        hits_d  = hits_q + 2'd1;
                        state_d = S_CLR_D;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLR_X: if (!grid_busy) state_d = S_ADDR_Y;
            S_CLR_Y: if (!grid_busy) state_d = S_DONE;
            S_CLR_D: if (!grid_busy) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bx_q     <= 9'd0;
            by_q     <= 9'd0;
            dx_q     <= 1'b0;
            dy_q     <= 1'b0;
            row_q    <= 7'd0;
            col_q    <= 7'd0;
            oob_q    <= 1'b0;
            flip_x_q <= 1'b0;
            flip_y_q <= 1'b0;
            hits_q   <= 2'd0;
            kind_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            row_q    <= row_d;
            col_q    <= col_d;
            oob_q    <= oob_d;
            flip_x_q <= flip_x_d;
            flip_y_q <= flip_y_d;
            hits_q   <= hits_d;
            kind_q   <= kind_d;
        end
    end

    logic in_clr;
    assign in_clr = (state_q == S_CLR_X) || (state_q == S_CLR_Y) || (state_q == S_CLR_D);

    // Gated by reset so an aborting tick can never land a CLEAR on the grid.
    assign grid_en   = in_clr && !grid_busy && !reset;
    assign grid_func = 2'b00;
    assign grid_in   = 3'b000;
    assign grid_row  = row_q;
    assign grid_col  = col_q;
    assign done      = (state_q == S_DONE);
    assign flip_x    = flip_x_q;
    assign flip_y    = flip_y_q;
    assign hits      = hits_q;
    assign hit_kind  = kind_q;

endmodule
